// File: rtl/nyan_spi_master.sv
// nyan_spi_master: SPI mode-0 master that moves one byte per request over
// MOSI/MISO.  Slave select stays low across a multi-byte transaction until a
// byte flagged 'last' completes; SCK is paced slowly enough for a slave that
// oversamples SCK through a 2-flop synchronizer.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   start        request to send din (accepted only while busy = 0)
//   last         sampled with start; ends the transaction after this byte
//   din[7:0]     byte to transmit, MSB first
//   busy         byte in flight or SS setup/hold/idle timing running
//   done         one-cycle pulse; dout valid from this cycle on
//   dout[7:0]    received byte, held until the next done
//   ss           slave select, active-low
//   sck          SPI clock, idles low
//   mosi         master-out data
//   miso         master-in data (asynchronous, synchronized internally)
module nyan_spi_master #(
    parameter int unsigned CLK_DIV  = 8,
    parameter int unsigned SS_SETUP = 4,
    parameter int unsigned SS_HOLD  = 4,
    parameter int unsigned SS_IDLE  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       last,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic [7:0] dout,
    output logic       ss,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);

    localparam int unsigned MAX_AB = (CLK_DIV > SS_SETUP) ? CLK_DIV : SS_SETUP;
    localparam int unsigned MAX_CD = (SS_HOLD > SS_IDLE) ? SS_HOLD : SS_IDLE;
    localparam int unsigned MAX_LD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CW     = (MAX_LD > 1) ? $clog2(MAX_LD) : 1;

    localparam logic [CW-1:0] DIV_LD   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LD = CW'(SS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(SS_HOLD - 1);
    localparam logic [CW-1:0] IDLE_LD  = CW'(SS_IDLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        GAP,
        HOLD,
        SSIDLE
    } state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic [2:0]  bit_cnt;
    logic [6:0]  tx_sr;      // bits still to be sent; the current bit sits in mosi
    logic [6:0]  rx_sr;      // first seven received bits; the eighth comes straight from miso_s
    logic        last_q;
    logic [1:0]  miso_sync;
    logic        miso_s;

    assign miso_s = miso_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            last_q    <= 1'b0;
            miso_sync <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dout      <= '0;
            ss        <= 1'b1;
            sck       <= 1'b0;
            mosi      <= 1'b0;
        end else begin
            miso_sync <= {miso_sync[0], miso};
            done      <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= SETUP;
                        ss     <= 1'b0;
                        busy   <= 1'b1;
                        mosi   <= din[7];
                        tx_sr  <= din[6:0];
                        last_q <= last;
                        cnt    <= SETUP_LD;
                    end
                end

                SETUP: begin
                    if (cnt == '0) begin
                        state   <= XFER;
                        cnt     <= DIV_LD;
                        bit_cnt <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                XFER: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!sck) begin
                        sck <= 1'b1;
                        cnt <= DIV_LD;
                    end else begin
                        // Falling edge: capture MISO, present the next MOSI bit.
                        sck     <= 1'b0;
                        cnt     <= DIV_LD;
                        rx_sr   <= {rx_sr[5:0], miso_s};
                        mosi    <= tx_sr[6];
                        tx_sr   <= {tx_sr[5:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            dout <= {rx_sr, miso_s};
                            done <= 1'b1;
                            if (last_q) begin
                                state <= HOLD;
                                cnt   <= HOLD_LD;
                            end else begin
                                state <= GAP;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end

                GAP: begin
                    // SS stays asserted; the next byte starts without a setup phase.
                    if (start) begin
                        state   <= XFER;
                        busy    <= 1'b1;
                        mosi    <= din[7];
                        tx_sr   <= din[6:0];
                        last_q  <= last;
                        cnt     <= DIV_LD;
                        bit_cnt <= '0;
                    end
                end

                HOLD: begin
                    if (cnt == '0) begin
                        state <= SSIDLE;
                        ss    <= 1'b1;
                        cnt   <= IDLE_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                SSIDLE: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    ss    <= 1'b1;
                    sck   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nyan_spi_master.sv
// Bench for nyan_spi_master: a default-parameter instance exercised with
// loopback and a behavioural mode-0 slave, plus a slow instance
// (CLK_DIV = 255, SS timings = 1) checking phase lengths.
module tb_nyan_spi_master;

    localparam int unsigned A_DIV   = 8;
    localparam int unsigned A_SETUP = 4;
    localparam int unsigned A_HOLD  = 4;
    localparam int unsigned A_IDLE  = 4;
    localparam int unsigned B_DIV   = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- DUT A (defaults) ----------------
    logic       rst, start, last, busy, done, ss, sck, mosi, miso;
    logic [7:0] din, dout;
    logic       loopback;
    logic [7:0] slave_byte;
    logic       miso_slave;
    logic [2:0] sidx;

    nyan_spi_master #(
        .CLK_DIV (A_DIV),
        .SS_SETUP(A_SETUP),
        .SS_HOLD (A_HOLD),
        .SS_IDLE (A_IDLE)
    ) dut_a (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .last (last),
        .din  (din),
        .busy (busy),
        .done (done),
        .dout (dout),
        .ss   (ss),
        .sck  (sck),
        .mosi (mosi),
        .miso (miso)
    );

    // ---------------- DUT B (slowest legal SCK) ----------------
    logic       rst_b, start_b, last_b, busy_b, done_b, ss_b, sck_b, mosi_b;
    logic [7:0] din_b, dout_b;

    nyan_spi_master #(
        .CLK_DIV (B_DIV),
        .SS_SETUP(1),
        .SS_HOLD (1),
        .SS_IDLE (1)
    ) dut_b (
        .clk  (clk),
        .rst  (rst_b),
        .start(start_b),
        .last (last_b),
        .din  (din_b),
        .busy (busy_b),
        .done (done_b),
        .dout (dout_b),
        .ss   (ss_b),
        .sck  (sck_b),
        .mosi (mosi_b),
        .miso (mosi_b)
    );

    // ---------------- monitors (sampled on the falling clk edge) ----------------
    int unsigned rise_q[$];
    logic [7:0]  mosi_cap = 8'h00;
    int unsigned fall_total = 0;
    int unsigned fall_base  = 0;
    int unsigned done_total = 0;
    int unsigned done_cyc   = 0;
    int unsigned ss_rise_total = 0;
    int unsigned ss_rise_cyc   = 0;
    int unsigned busy_fall_total = 0;
    int unsigned busy_fall_cyc   = 0;
    logic sck_q = 1'b0, ss_q = 1'b1, busy_q = 1'b0;

    always @(negedge clk) begin
        if (sck && !sck_q) begin
            rise_q.push_back(cyc);
            mosi_cap = {mosi_cap[6:0], mosi};
        end
        if (!sck && sck_q) fall_total++;
        if (done) begin
            done_total++;
            done_cyc = cyc;
        end
        if (ss && !ss_q) begin
            ss_rise_total++;
            ss_rise_cyc = cyc;
        end
        if (!busy && busy_q) begin
            busy_fall_total++;
            busy_fall_cyc = cyc;
        end
        sck_q  = sck;
        ss_q   = ss;
        busy_q = busy;
    end

    // Mode-0 slave: presents bit 7 first, advances after each SCK fall.
    always_comb begin
        sidx       = 3'd7 - 3'(fall_total - fall_base);
        miso_slave = slave_byte[sidx];
    end
    assign miso = loopback ? mosi : miso_slave;

    int unsigned edges_b[$];
    int unsigned done_b_total = 0, done_b_cyc = 0;
    int unsigned ss_b_rise_cyc = 0, busy_b_fall_total = 0, busy_b_fall_cyc = 0;
    logic sck_b_q = 1'b0, ss_b_q = 1'b1, busy_b_q = 1'b0;

    always @(negedge clk) begin
        if (sck_b != sck_b_q) edges_b.push_back(cyc);
        if (done_b) begin
            done_b_total++;
            done_b_cyc = cyc;
        end
        if (ss_b && !ss_b_q) ss_b_rise_cyc = cyc;
        if (!busy_b && busy_b_q) begin
            busy_b_fall_total++;
            busy_b_fall_cyc = cyc;
        end
        sck_b_q  = sck_b;
        ss_b_q   = ss_b;
        busy_b_q = busy_b;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One byte on DUT A.  Called just after a rising edge.  'first' means the
    // byte opens a transaction (SETUP phase precedes it); 'inject' fires
    // ignored start pulses with din = 0 during XFER, HOLD and SSIDLE.
    task automatic xfer_byte(input logic [7:0] b, input logic lst, input logic [7:0] sb,
                             input logic first, input logic inject);
        int unsigned t0, lead, rb, db, sb0, bb0, w, gerr;
        logic [7:0] exp_rx;
        exp_rx     = loopback ? b : sb;
        slave_byte = sb;
        fall_base  = fall_total;
        rb  = rise_q.size();
        db  = done_total;
        sb0 = ss_rise_total;
        start = 1'b1;
        din   = b;
        last  = lst;
        t0    = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        din   = 8'($urandom);
        last  = 1'($urandom);
        lead  = first ? A_SETUP : 0;
        w = 0;
        while (done_total == db && w < 20 * A_DIV + 50) begin
            @(posedge clk); #1;
            w++;
            start = inject && (cyc == t0 + 1 + lead + 3 * A_DIV);
            if (start) din = 8'h00;
        end
        start = 1'b0;
        check("done_count", done_total - db, 1);
        check("done_cycle", done_cyc - t0, 1 + lead + 16 * A_DIV);
        check("dout", dout, exp_rx);
        check("rise_count", rise_q.size() - rb, 8);
        if (rise_q.size() >= rb + 8) begin
            check("first_rise", rise_q[rb] - t0, 1 + lead + A_DIV);
            gerr = 0;
            for (int i = 1; i < 8; i++)
                if (rise_q[rb + i] - rise_q[rb + i - 1] != 2 * A_DIV) gerr++;
            check("rise_spacing", gerr, 0);
            check("mosi_bits", mosi_cap, b);
        end
        if (lst) begin
            bb0 = busy_fall_total;
            w = 0;
            while (busy_fall_total == bb0 && w < A_HOLD + A_IDLE + 20) begin
                @(posedge clk); #1;
                w++;
                start = inject && (cyc == done_cyc + 2 || cyc == done_cyc + A_HOLD + 1 ||
                                   cyc == done_cyc + A_HOLD + A_IDLE - 1);
                if (start) din = 8'h00;
            end
            start = 1'b0;
            check("ss_rise_cycle", ss_rise_cyc - done_cyc, A_HOLD);
            check("ss_rises", ss_rise_total - sb0, 1);
            check("busy_fall_cycle", busy_fall_cyc - done_cyc, A_HOLD + A_IDLE);
            repeat (3) @(posedge clk);
            #1;
            check("idle_busy", busy, 0);
            check("idle_ss", ss, 1);
            check("no_extra_rises", rise_q.size() - rb, 8);
            check("dout_held", dout, exp_rx);
        end else begin
            check("gap_busy", busy, 0);
            check("gap_ss", ss, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned w, rb, db, d0, s0, viol, t0, eb, bfb, bad, n;
        logic [7:0] x;

        rst = 1'b1; start = 1'b0; last = 1'b0; din = 8'h00;
        rst_b = 1'b1; start_b = 1'b0; last_b = 1'b0; din_b = 8'h00;
        loopback = 1'b1; slave_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ss", ss, 1);
        check("rst_sck", sck, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dout", dout, 8'h00);
        rst = 1'b0;
        rst_b = 1'b0;
        @(posedge clk); #1;

        // Single byte loopback: done at +133, ss high at +137, busy low at +141.
        loopback = 1'b1;
        xfer_byte(8'hA5, 1'b1, 8'h00, 1'b1, 1'b0);

        // Two-byte transaction against the behavioural slave.
        loopback = 1'b0;
        d0 = done_total;
        s0 = ss_rise_total;
        xfer_byte(8'h01, 1'b0, 8'h3C, 1'b1, 1'b0);
        xfer_byte(8'h02, 1'b1, 8'hC3, 1'b0, 1'b0);
        check("two_byte_dones", done_total - d0, 2);
        check("two_byte_ss_rises", ss_rise_total - s0, 1);

        // GAP holds indefinitely.
        loopback = 1'b1;
        x = 8'($urandom);
        xfer_byte(x, 1'b0, 8'h00, 1'b1, 1'b0);
        viol = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (ss !== 1'b0 || sck !== 1'b0 || busy !== 1'b0) viol++;
        end
        check("gap_hold_violations", viol, 0);
        xfer_byte(8'hFF, 1'b1, 8'h00, 1'b0, 1'b0);

        // Starts while busy are ignored.
        x = 8'($urandom_range(1, 255));
        xfer_byte(x, 1'b1, 8'h00, 1'b1, 1'b1);

        // Reset after the 4th SCK rise aborts the byte.
        rb = rise_q.size();
        db = done_total;
        start = 1'b1; din = 8'($urandom); last = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        while (rise_q.size() < rb + 4 && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_ss", ss, 1);
        check("abort_sck", sck, 0);
        check("abort_busy", busy, 0);
        check("abort_dout", dout, 8'h00);
        repeat (300) @(posedge clk);
        #1;
        check("abort_no_done", done_total - db, 0);
        check("abort_rises", rise_q.size() - rb, 4);
        xfer_byte(8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);

        // Random transactions of 1..3 bytes, loopback or slave.
        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(1, 3);
            loopback = 1'($urandom);
            for (int unsigned i = 0; i < n; i++)
                xfer_byte(8'($urandom), i == n - 1, 8'($urandom), i == 0, 1'b0);
        end

        // Slow instance: every SCK phase exactly 255 cycles.
        eb  = edges_b.size();
        db  = done_b_total;
        bfb = busy_b_fall_total;
        start_b = 1'b1; din_b = 8'h81; last_b = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        start_b = 1'b0; din_b = 8'h00;
        w = 0;
        while (busy_b_fall_total == bfb && w < 16 * B_DIV + 100) begin
            @(posedge clk); #1;
            w++;
        end
        check("b_edges", edges_b.size() - eb, 16);
        if (edges_b.size() >= eb + 16) begin
            check("b_first_low_phase", edges_b[eb] - t0, 2 + B_DIV);
            bad = 0;
            for (int i = 1; i < 16; i++)
                if (edges_b[eb + i] - edges_b[eb + i - 1] != B_DIV) bad++;
            check("b_phase_len", bad, 0);
        end
        check("b_done_count", done_b_total - db, 1);
        check("b_done_cycle", done_b_cyc - t0, 2 + 16 * B_DIV);
        check("b_dout", dout_b, 8'h81);
        check("b_ss_rise", ss_b_rise_cyc - done_b_cyc, 1);
        check("b_busy_fall", busy_b_fall_cyc - done_b_cyc, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
